// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdmi_pkg;

    localparam int CNT_W        = 12;
    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;

    typedef enum logic [1:0] {
        PERIOD_CONTROL  = 2'd0,
        PERIOD_PREAMBLE = 2'd1,
        PERIOD_GUARD    = 2'd2,
        PERIOD_VIDEO    = 2'd3
    } period_t;

endpackage

// File: rtl/hdmi_raster_counter.sv
// Wrap counter 0..MAX with synchronous clear and advance; wrap flags the terminal count.
// Latency: count updates on the clock edge after advance; wrap is combinational on count.
// Backpressure: none; counts whenever advance is high.
module hdmi_raster_counter
    import hdmi_pkg::*;
#(
    parameter int unsigned MAX = 799
) (
    input  logic             hdmi_pixel_clock,
    input  logic             hdmi_pixel_resetn,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    assign wrap = (cnt == MAX_C);

    always_ff @(posedge hdmi_pixel_clock or negedge hdmi_pixel_resetn) begin
        if (!hdmi_pixel_resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Raster timing and per-slot HDMI period classification driving TMDS word selection.
// Latency: all outputs are a 1-cycle registered decode of the raster counters.
// Backpressure: none; enable low parks counters at origin and idles outputs.
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic             hdmi_pixel_clock,
    input  logic             hdmi_pixel_resetn,
    input  logic             enable,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [1:0]       period,
    output logic [3:0]       ctl,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL >= 4096 || V_TOTAL >= 4096) begin : g_bad_total
        $error("hdmi_period_scheduler: raster totals must be below 4096");
    end
    if (H_BACK < PREAMBLE_LEN + GUARD_LEN) begin : g_bad_back
        $error("hdmi_period_scheduler: H_BACK too short for preamble plus guard band");
    end

    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] GB_START  = CNT_W'(H_TOTAL - GUARD_LEN);
    localparam logic [CNT_W-1:0] PRE_START = CNT_W'(H_TOTAL - GUARD_LEN - PREAMBLE_LEN);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;
    logic             run_q;
    logic             out_en;

    hdmi_raster_counter #(.MAX(H_TOTAL - 1)) u_h_cnt (
        .hdmi_pixel_clock  (hdmi_pixel_clock),
        .hdmi_pixel_resetn (hdmi_pixel_resetn),
        .clear             (!enable),
        .advance           (enable),
        .cnt               (h_cnt),
        .wrap              (h_last)
    );

    hdmi_raster_counter #(.MAX(V_TOTAL - 1)) u_v_cnt (
        .hdmi_pixel_clock  (hdmi_pixel_clock),
        .hdmi_pixel_resetn (hdmi_pixel_resetn),
        .clear             (!enable),
        .advance           (enable && h_last),
        .cnt               (v_cnt),
        .wrap              (v_last)
    );

    // On the edge where enable drops the counters still hold a valid slot, so it
    // is emitted once more before the outputs idle.
    assign out_en = enable || run_q;

    period_t          period_d;
    period_t          period_q;
    logic             next_line_active;
    logic             hsync_d;
    logic             vsync_d;
    logic [3:0]       ctl_d;
    logic             frame_start_d;

    always_comb begin
        period_d         = PERIOD_CONTROL;
        ctl_d            = 4'b0000;
        hsync_d          = !HSYNC_POL;
        vsync_d          = !VSYNC_POL;
        frame_start_d    = 1'b0;
        next_line_active = v_last ? 1'b1 : ((v_cnt + 12'd1) < V_ACT_C);

        if (out_en) begin
            if (h_cnt < H_ACT_C && v_cnt < V_ACT_C) begin
                period_d = PERIOD_VIDEO;
            end else if (next_line_active && h_cnt >= GB_START) begin
                period_d = PERIOD_GUARD;
            end else if (next_line_active && h_cnt >= PRE_START) begin
                period_d = PERIOD_PREAMBLE;
                ctl_d    = CTL_VIDEO_PREAMBLE;
            end

            if (h_cnt >= HS_START && h_cnt < HS_END) hsync_d = HSYNC_POL;
            if (v_cnt >= VS_START && v_cnt < VS_END) vsync_d = VSYNC_POL;
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge hdmi_pixel_clock or negedge hdmi_pixel_resetn) begin
        if (!hdmi_pixel_resetn) begin
            run_q       <= 1'b0;
            period_q    <= PERIOD_CONTROL;
            ctl         <= 4'b0000;
            hsync       <= !HSYNC_POL;
            vsync       <= !VSYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
        end else begin
            run_q       <= enable;
            period_q    <= period_d;
            ctl         <= ctl_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            de          <= (period_d == PERIOD_VIDEO);
            frame_start <= frame_start_d;
            pixel_x     <= out_en ? h_cnt : '0;
            pixel_y     <= out_en ? v_cnt : '0;
        end
    end

    assign period = period_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler on a small 25x8 raster.
// Latency: expects outputs for slot k after the k+1-th active edge.
// Backpressure: n/a.
module tb_hdmi_period_scheduler;

    logic        hdmi_pixel_clock;
    logic        hdmi_pixel_resetn;
    logic        enable;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [1:0]  period;
    logic [3:0]  ctl;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        frame_start;

    hdmi_period_scheduler #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(12),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .hdmi_pixel_clock  (hdmi_pixel_clock),
        .hdmi_pixel_resetn (hdmi_pixel_resetn),
        .enable            (enable),
        .hsync             (hsync),
        .vsync             (vsync),
        .de                (de),
        .period            (period),
        .ctl               (ctl),
        .pixel_x           (pixel_x),
        .pixel_y           (pixel_y),
        .frame_start       (frame_start)
    );

    initial begin
        hdmi_pixel_clock = 1'b0;
        forever #5 hdmi_pixel_clock = ~hdmi_pixel_clock;
    end

    typedef struct {
        int         x;
        int         y;
        logic       hs;
        logic       vs;
        logic       de;
        logic [1:0] p;
        logic [3:0] ctl;
        logic       fs;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    localparam logic [33:0] IDLE = {1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 12'd0, 12'd0};

    function automatic logic [33:0] obs();
        return {hsync, vsync, de, period, ctl, frame_start, pixel_x, pixel_y};
    endfunction

    function automatic logic [33:0] expv(input vec_t v);
        return {v.hs, v.vs, v.de, v.p, v.ctl, v.fs, 12'(v.x), 12'(v.y)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic goto(input int target);
        while (t < target) begin
            @(negedge hdmi_pixel_clock);
            t++;
        end
    endtask

    vec_t vecs [22];
    vec_t v;
    int   de_n, fs_n, hs_n, vs_n, pre_n, gb_n;

    initial begin
        vecs = '{
            '{0, 0, 1, 1, 1, 3, 4'b0000, 1},
            '{7, 0, 1, 1, 1, 3, 4'b0000, 0},
            '{8, 0, 1, 1, 0, 0, 4'b0000, 0},
            '{10, 0, 0, 1, 0, 0, 4'b0000, 0},
            '{12, 0, 0, 1, 0, 0, 4'b0000, 0},
            '{13, 0, 1, 1, 0, 0, 4'b0000, 0},
            '{14, 0, 1, 1, 0, 0, 4'b0000, 0},
            '{15, 0, 1, 1, 0, 1, 4'b0001, 0},
            '{22, 0, 1, 1, 0, 1, 4'b0001, 0},
            '{23, 0, 1, 1, 0, 2, 4'b0000, 0},
            '{24, 0, 1, 1, 0, 2, 4'b0000, 0},
            '{0, 1, 1, 1, 1, 3, 4'b0000, 0},
            '{15, 3, 1, 1, 0, 0, 4'b0000, 0},
            '{23, 3, 1, 1, 0, 0, 4'b0000, 0},
            '{0, 4, 1, 1, 0, 0, 4'b0000, 0},
            '{10, 4, 0, 1, 0, 0, 4'b0000, 0},
            '{0, 5, 1, 0, 0, 0, 4'b0000, 0},
            '{11, 6, 0, 0, 0, 0, 4'b0000, 0},
            '{0, 7, 1, 1, 0, 0, 4'b0000, 0},
            '{15, 7, 1, 1, 0, 1, 4'b0001, 0},
            '{23, 7, 1, 1, 0, 2, 4'b0000, 0},
            '{24, 7, 1, 1, 0, 2, 4'b0000, 0}
        };

        hdmi_pixel_resetn = 1'b0;
        enable            = 1'b0;
        repeat (5) begin
            @(negedge hdmi_pixel_clock);
            check("reset", 64'(obs()), 64'(IDLE));
        end
        hdmi_pixel_resetn = 1'b1;
        repeat (20) begin
            @(negedge hdmi_pixel_clock);
            check("idle_en0", 64'(obs()), 64'(IDLE));
        end

        // Frame 0: directed slots.
        enable = 1'b1;
        @(negedge hdmi_pixel_clock);
        t = 0;
        foreach (vecs[i]) begin
            goto(vecs[i].y * 25 + vecs[i].x);
            check($sformatf("slot_x%0d_y%0d", vecs[i].x, vecs[i].y), 64'(obs()), 64'(expv(vecs[i])));
        end

        // Frame 1: whole-frame totals.
        goto(200);
        v = '{0, 0, 1, 1, 1, 3, 4'b0000, 1};
        check("frame1_start", 64'(obs()), 64'(expv(v)));
        de_n = 0; fs_n = 0; hs_n = 0; vs_n = 0; pre_n = 0; gb_n = 0;
        for (int i = 0; i < 200; i++) begin
            de_n  += int'(de);
            fs_n  += int'(frame_start);
            hs_n  += int'(!hsync);
            vs_n  += int'(!vsync);
            pre_n += int'(period == 2'd1 && ctl == 4'b0001);
            gb_n  += int'(period == 2'd2);
            @(negedge hdmi_pixel_clock);
            t++;
        end
        check("de_per_frame", 64'(de_n), 64'd32);
        check("fs_per_frame", 64'(fs_n), 64'd1);
        check("hsync_low", 64'(hs_n), 64'd24);
        check("vsync_low", 64'(vs_n), 64'd50);
        check("preamble_slots", 64'(pre_n), 64'd32);
        check("guard_slots", 64'(gb_n), 64'd8);

        // Enable dropped at (5,2) of frame 2.
        goto(455);
        v = '{5, 2, 1, 1, 1, 3, 4'b0000, 0};
        check("pre_drop", 64'(obs()), 64'(expv(v)));
        enable = 1'b0;
        @(negedge hdmi_pixel_clock);
        v = '{6, 2, 1, 1, 1, 3, 4'b0000, 0};
        check("drop_drain", 64'(obs()), 64'(expv(v)));
        repeat (4) begin
            @(negedge hdmi_pixel_clock);
            check("drop_idle", 64'(obs()), 64'(IDLE));
        end

        enable = 1'b1;
        @(negedge hdmi_pixel_clock);
        t = 0;
        v = '{0, 0, 1, 1, 1, 3, 4'b0000, 1};
        check("reenable", 64'(obs()), 64'(expv(v)));
        @(negedge hdmi_pixel_clock);
        t = 1;
        v = '{1, 0, 1, 1, 1, 3, 4'b0000, 0};
        check("reenable_next", 64'(obs()), 64'(expv(v)));

        // Asynchronous reset mid-preamble at (17,1).
        goto(42);
        v = '{17, 1, 1, 1, 0, 1, 4'b0001, 0};
        check("pre_arst", 64'(obs()), 64'(expv(v)));
        #2 hdmi_pixel_resetn = 1'b0;
        #1 check("arst_immediate", 64'(obs()), 64'(IDLE));
        @(negedge hdmi_pixel_clock);
        hdmi_pixel_resetn = 1'b1;
        @(negedge hdmi_pixel_clock);
        v = '{0, 0, 1, 1, 1, 3, 4'b0000, 1};
        check("arst_restart", 64'(obs()), 64'(expv(v)));
        @(negedge hdmi_pixel_clock);
        v = '{1, 0, 1, 1, 1, 3, 4'b0000, 0};
        check("arst_next", 64'(obs()), 64'(expv(v)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
